// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        RESET_WAIT,
        RUN,
        DRAIN
    } fetch_state_e;

    localparam int unsigned PC_INCREMENT  = 4;
    localparam int unsigned FETCH_DEPTH   = 2;
    // Stale responses can pile up across back-to-back redirects; 8 bits is ample headroom.
    localparam int unsigned DISCARD_WIDTH = 8;
    localparam int unsigned PERF_WIDTH    = 16;

    function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] value);
        return (&value) ? value : value + PERF_WIDTH'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small in-order FIFO holding {pc, instr} pairs; synchronous flush beats push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DEPTH         = FETCH_DEPTH,
    parameter int unsigned CNT_WIDTH     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [ADDRESS_WIDTH-1:0] push_pc,
    input  logic [DATA_WIDTH-1:0]    push_instr,
    input  logic                     pop,
    output logic [ADDRESS_WIDTH-1:0] head_pc,
    output logic [DATA_WIDTH-1:0]    head_instr,
    output logic                     not_empty,
    output logic [CNT_WIDTH-1:0]     count
);

    localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [ADDRESS_WIDTH-1:0] pc_mem    [DEPTH];
    logic [DATA_WIDTH-1:0]    instr_mem [DEPTH];
    logic [PTR_WIDTH-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_WIDTH-1:0]     count_q;
    logic                     full, do_push, do_pop;

    function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] ptr);
        return (ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr + PTR_WIDTH'(1);
    endfunction

    assign full      = (count_q == CNT_WIDTH'(DEPTH));
    assign not_empty = (count_q != '0);
    assign do_pop    = pop && not_empty;
    // When full, a same-cycle pop frees the head slot the write lands in.
    assign do_push   = push && (!full || do_pop);

    assign head_pc    = pc_mem[rd_ptr_q];
    assign head_instr = instr_mem[rd_ptr_q];
    assign count      = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                pc_mem[wr_ptr_q]    <= push_pc;
                instr_mem[wr_ptr_q] <= push_instr;
                wr_ptr_q            <= ptr_next(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_WIDTH'(1);
                2'b01:   count_q <= count_q - CNT_WIDTH'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencing, redirect with stale-response discard, decode FIFO.
// Define FETCH_PERF_EN to add the perf_redirects / perf_dropped saturating counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDRESS_WIDTH = 8,
    parameter int unsigned DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_base,
    input  logic [DATA_WIDTH-1:0]    immext,
    output logic                     imem_req_valid,
    input  logic                     imem_req_ready,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_resp_valid,
    input  logic [DATA_WIDTH-1:0]    imem_resp_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [DATA_WIDTH-1:0]    instr,
    output logic [ADDRESS_WIDTH-1:0] instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_WIDTH-1:0]    perf_redirects,
    output logic [PERF_WIDTH-1:0]    perf_dropped
`endif
);

    localparam int unsigned CNT_WIDTH = $clog2(FETCH_DEPTH + 1);
    localparam int unsigned OCC_WIDTH = CNT_WIDTH + 1;

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDRESS_WIDTH-1:0] target;
    logic [DISCARD_WIDTH-1:0] discard_q, discard_d, in_flight;
    logic [ADDRESS_WIDTH-1:0] tag_head_q, tag_head_d, tag_tail_q, tag_tail_d;
    logic [CNT_WIDTH-1:0]     tag_cnt_q, tag_cnt_d;
    logic [CNT_WIDTH-1:0]     fifo_count;
    logic [OCC_WIDTH-1:0]     occupancy;
    logic                     req_fire, resp_take, resp_drop, fifo_pop;

    assign target    = ADDRESS_WIDTH'(immext + DATA_WIDTH'(redirect_base));
    assign occupancy = OCC_WIDTH'(tag_cnt_q) + OCC_WIDTH'(fifo_count);

    assign imem_addr      = fetch_pc_q;
    assign imem_req_valid = (state_q != RESET_WAIT) && !redirect &&
                            (occupancy < OCC_WIDTH'(FETCH_DEPTH));
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses are in order: the first discard_q of them belong to pre-redirect requests.
    assign resp_take = imem_resp_valid && !redirect && (discard_q == '0) && (tag_cnt_q != '0);
    assign resp_drop = imem_resp_valid && (redirect || (discard_q != '0));
    assign fifo_pop  = instr_valid && instr_ready && !redirect;
    assign in_flight = discard_q + DISCARD_WIDTH'(tag_cnt_q);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect) begin
            fetch_pc_d = target;
        end else if (req_fire) begin
            fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(PC_INCREMENT);
        end
    end

    always_comb begin
        discard_d = discard_q;
        if (redirect) begin
            discard_d = (imem_resp_valid && (in_flight != '0)) ?
                        in_flight - DISCARD_WIDTH'(1) : in_flight;
        end else if (imem_resp_valid && (discard_q != '0)) begin
            discard_d = discard_q - DISCARD_WIDTH'(1);
        end
    end

    // Two-entry tag queue; occupancy gating guarantees no push while it is full.
    always_comb begin
        tag_head_d = tag_head_q;
        tag_tail_d = tag_tail_q;
        tag_cnt_d  = tag_cnt_q;
        if (redirect) begin
            tag_cnt_d = '0;
        end else begin
            case ({req_fire, resp_take})
                2'b10: begin
                    if (tag_cnt_q == '0) tag_head_d = fetch_pc_q;
                    else                 tag_tail_d = fetch_pc_q;
                    tag_cnt_d = tag_cnt_q + CNT_WIDTH'(1);
                end
                2'b01: begin
                    tag_head_d = tag_tail_q;
                    tag_cnt_d  = tag_cnt_q - CNT_WIDTH'(1);
                end
                2'b11: begin
                    if (tag_cnt_q == CNT_WIDTH'(1)) begin
                        tag_head_d = fetch_pc_q;
                    end else begin
                        tag_head_d = tag_tail_q;
                        tag_tail_d = fetch_pc_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET_WAIT: state_d = RUN;
            RUN:        if (redirect && (discard_d != '0)) state_d = DRAIN;
            DRAIN:      if (!redirect && (discard_d == '0)) state_d = RUN;
            default:    state_d = RESET_WAIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RESET_WAIT;
            fetch_pc_q <= '0;
            discard_q  <= '0;
            tag_head_q <= '0;
            tag_tail_q <= '0;
            tag_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            discard_q  <= discard_d;
            tag_head_q <= tag_head_d;
            tag_tail_q <= tag_tail_d;
            tag_cnt_q  <= tag_cnt_d;
        end
    end

    fetch_fifo #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .DATA_WIDTH    (DATA_WIDTH),
        .DEPTH         (FETCH_DEPTH),
        .CNT_WIDTH     (CNT_WIDTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (redirect),
        .push       (resp_take),
        .push_pc    (tag_head_q),
        .push_instr (imem_resp_data),
        .pop        (fifo_pop),
        .head_pc    (instr_pc),
        .head_instr (instr),
        .not_empty  (instr_valid),
        .count      (fifo_count)
    );

`ifdef FETCH_PERF_EN
    logic [PERF_WIDTH-1:0] perf_redirects_q, perf_dropped_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_redirects_q <= '0;
            perf_dropped_q   <= '0;
        end else begin
            if (redirect)  perf_redirects_q <= sat_inc(perf_redirects_q);
            if (resp_drop) perf_dropped_q   <= sat_inc(perf_dropped_q);
        end
    end

    assign perf_redirects = perf_redirects_q;
    assign perf_dropped   = perf_dropped_q;
`else
    logic unused_drop;
    assign unused_drop = resp_drop;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: target table, directed corner sequences, random traffic.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [7:0]  redirect_base;
    logic [31:0] immext;
    logic        imem_req_valid, imem_req_ready;
    logic [7:0]  imem_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        instr_valid, instr_ready;
    logic [31:0] instr;
    logic [7:0]  instr_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .redirect        (redirect),
        .redirect_base   (redirect_base),
        .immext          (immext),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] mem_q[$];    // addresses accepted by the memory, awaiting response
    logic [7:0] got_pcs[$];  // PCs delivered to decode
    logic [7:0] m_req_pc, m_exp_pc;
    bit         prev_redir;
    bit         last_req_valid;
    logic [7:0] last_addr;
    int         req_count, deliv_count;

    typedef struct {
        logic [7:0]  base;
        logic [31:0] imm;
        logic [7:0]  exp_addr;
    } vec_t;
    vec_t vecs[7];

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        return {8'hC0, a ^ 8'h5A, 8'hDE, a};
    endfunction

    function automatic logic [7:0] tgt(input logic [7:0] b, input logic [31:0] i);
        logic [31:0] s;
        s = i + {24'd0, b};
        return s[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, sample 1 time unit later, update the model.
    task automatic step(input bit redir, input logic [7:0] base, input logic [31:0] imm,
                        input bit rq_rdy, input bit in_rdy, input bit resp_en);
        logic [7:0] a;
        @(negedge clk);
        redirect       = redir;
        redirect_base  = base;
        immext         = imm;
        imem_req_ready = rq_rdy;
        instr_ready    = in_rdy;
        if (resp_en && mem_q.size() != 0) begin
            a               = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(a);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
        #1;
        last_req_valid = imem_req_valid;
        last_addr      = imem_addr;
        if (prev_redir) check("flush_valid", 32'(instr_valid), 32'd0);
        if (redir) check("redir_blocks_req", 32'(imem_req_valid), 32'd0);
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", 32'(imem_addr), 32'(m_req_pc));
            mem_q.push_back(imem_addr);
            m_req_pc = m_req_pc + 8'd4;
            req_count++;
        end
        if (instr_valid && instr_ready && !redir) begin
            check("instr_pc", 32'(instr_pc), 32'(m_exp_pc));
            check("instr_data", instr, mem_word(instr_pc));
            got_pcs.push_back(instr_pc);
            m_exp_pc = m_exp_pc + 8'd4;
            deliv_count++;
        end
        if (redir) begin
            m_req_pc = tgt(base, imm);
            m_exp_pc = tgt(base, imm);
        end
        prev_redir = redir;
    endtask

    // Asynchronous reset with immediate output check; the memory side resets too.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        redirect = 1'b0; imem_req_ready = 1'b0; instr_ready = 1'b0; imem_resp_valid = 1'b0;
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        mem_q.delete();
        got_pcs.delete();
        m_req_pc = '0; m_exp_pc = '0; prev_redir = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("reset_wait_req_valid", 32'(imem_req_valid), 32'd0);
    endtask

    initial begin
        int r0;
        rst = 1'b1; redirect = 1'b0; redirect_base = '0; immext = '0;
        imem_req_ready = 1'b0; instr_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
        req_count = 0; deliv_count = 0;
        m_req_pc = '0; m_exp_pc = '0; prev_redir = 1'b0;

        vecs[0] = '{8'h10, 32'hFFFF_FFF8, 8'h08};
        vecs[1] = '{8'hF0, 32'h0000_0020, 8'h10};
        vecs[2] = '{8'h04, 32'h0000_0100, 8'h04};
        vecs[3] = '{8'h03, 32'h0000_0000, 8'h03};
        vecs[4] = '{8'hFF, 32'h0000_0001, 8'h00};
        vecs[5] = '{8'h80, 32'hFFFF_FF80, 8'h00};
        vecs[6] = '{8'h7C, 32'h1234_5604, 8'h80};

        // Straight-line fetch with 1-cycle memory.
        do_reset();
        step(0, 8'h0, 32'h0, 1, 1, 1);
        check("first_run_req_valid", 32'(last_req_valid), 32'd1);
        repeat (8) step(0, 8'h0, 32'h0, 1, 1, 1);
        check("seq_len", 32'(got_pcs.size() >= 3), 32'd1);
        check("seq_pc0", 32'(got_pcs[0]), 32'h00);
        check("seq_pc1", 32'(got_pcs[1]), 32'h04);
        check("seq_pc2", 32'(got_pcs[2]), 32'h08);

        // Redirect target table.
        do_reset();
        foreach (vecs[i]) begin
            step(1, vecs[i].base, vecs[i].imm, 0, 0, 0);
            step(0, 8'h0, 32'h0, 0, 0, 0);
            check($sformatf("target_%0d", i), 32'(last_addr), 32'(vecs[i].exp_addr));
        end

        // Decode stalled: only two requests, then stall until a pop.
        do_reset();
        r0 = req_count;
        repeat (6) step(0, 8'h0, 32'h0, 1, 0, 1);
        check("stall_req_count", 32'(req_count - r0), 32'd2);
        check("stall_req_valid", 32'(last_req_valid), 32'd0);
        step(0, 8'h0, 32'h0, 1, 1, 1);
        step(0, 8'h0, 32'h0, 1, 0, 1);
        check("post_pop_req_valid", 32'(last_req_valid), 32'd1);

        // Redirect with two outstanding requests.
        do_reset();
        r0 = req_count;
        step(0, 8'h0, 32'h0, 1, 1, 0);
        step(0, 8'h0, 32'h0, 1, 1, 0);
        check("two_outstanding", 32'(req_count - r0), 32'd2);
        step(1, 8'h10, 32'hFFFF_FFF8, 1, 1, 0);
        got_pcs.delete();
        step(0, 8'h0, 32'h0, 1, 1, 1);
        check("redir_next_addr", 32'(last_addr), 32'h08);
        repeat (10) step(0, 8'h0, 32'h0, 1, 1, 1);
        check("redir_first_pc", 32'(got_pcs[0]), 32'h08);
        check("redir_second_pc", 32'(got_pcs[1]), 32'h0C);

        // PC wrap at the top of the address space.
        do_reset();
        step(1, 8'hF8, 32'h0, 1, 1, 1);
        got_pcs.delete();
        repeat (12) step(0, 8'h0, 32'h0, 1, 1, 1);
        check("wrap_pc0", 32'(got_pcs[0]), 32'hF8);
        check("wrap_pc1", 32'(got_pcs[1]), 32'hFC);
        check("wrap_pc2", 32'(got_pcs[2]), 32'h00);

        // Redirect while draining, with a stale response arriving that cycle.
        do_reset();
        step(0, 8'h0, 32'h0, 1, 1, 0);
        step(0, 8'h0, 32'h0, 1, 1, 0);
        step(1, 8'h40, 32'h0, 1, 1, 0);
        step(0, 8'h0, 32'h0, 1, 1, 0);
        step(1, 8'h80, 32'h0, 1, 1, 1);
        got_pcs.delete();
        repeat (12) step(0, 8'h0, 32'h0, 1, 1, 1);
        check("drain_redir_pc0", 32'(got_pcs[0]), 32'h80);
        check("drain_redir_pc1", 32'(got_pcs[1]), 32'h84);

        // Reset in the middle of a drain.
        do_reset();
        step(1, 8'h40, 32'h0, 0, 0, 0);
        repeat (4) step(0, 8'h0, 32'h0, 1, 0, 1);
        step(0, 8'h0, 32'h0, 1, 1, 0);
        step(0, 8'h0, 32'h0, 1, 0, 0);
        step(1, 8'h20, 32'h0, 0, 0, 0);
        do_reset();
        repeat (8) step(0, 8'h0, 32'h0, 1, 1, 1);
        check("post_rst_pc0", 32'(got_pcs[0]), 32'h00);

        // Random traffic against the model.
        do_reset();
        r0 = deliv_count;
        for (int n = 0; n < 3000; n++) begin
            bit          rd;
            logic [7:0]  b;
            logic [31:0] im;
            rd = ($urandom_range(0, 19) == 0);
            b  = 8'($urandom);
            im = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
            step(rd, b, im, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 1) == 1));
        end
        check("random_progress", 32'((deliv_count - r0) > 200), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, PC/instruction-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction and offset width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port redirect  input  1  take branch/jump this cycle.
REQ-006 SHALL have port redirect_base  input  ADDRESS_WIDTH  PC of redirecting instruction.
REQ-007 SHALL have port immext  input  DATA_WIDTH  sign-extended offset added to redirect_base.
REQ-008 SHALL have ports imem_req_valid (output, 1) and imem_req_ready (input, 1), the request handshake.
REQ-009 SHALL have port imem_addr  output  ADDRESS_WIDTH  request address.
REQ-010 SHALL have ports imem_resp_valid (input, 1) and imem_resp_data (input, DATA_WIDTH): in-order response, one per accepted request, latency >=1 cycle, no backpressure.
REQ-011 SHALL have ports instr_valid (output, 1) and instr_ready (input, 1), the decode handshake.
REQ-012 SHALL have ports instr (output, DATA_WIDTH) and instr_pc (output, ADDRESS_WIDTH): instruction and its address.

Function
REQ-013 SHALL compute target = low ADDRESS_WIDTH bits of (immext + zero-extended redirect_base); upper bits discarded, no alignment forced.
REQ-014 SHALL hold fetch_pc; on request handshake fetch_pc <= fetch_pc + 4, wrapping modulo 2^ADDRESS_WIDTH (0xFC -> 0x00 at AW=8).
REQ-015 SHALL drive imem_addr = fetch_pc and imem_req_valid = (state != RESET_WAIT) && !redirect && (outstanding + fifo_count < 2).
REQ-016 SHALL track request addresses in a 2-entry in-order tag queue so each response is paired with its PC.
REQ-017 SHALL push {tag, imem_resp_data} into the 2-entry output FIFO when a response arrives and discard_cnt == 0; instr_valid = FIFO non-empty; pop on instr_valid && instr_ready.
REQ-018 SHALL, on redirect: fetch_pc <= target, flush output FIFO and tag queue, set discard_cnt = requests outstanding after this cycle's response, drop any same-cycle response, deassert instr_valid next cycle.
REQ-019 SHALL, while discard_cnt > 0, drop each response and decrement discard_cnt; new requests permitted meanwhile.
REQ-020 SHALL implement FSM RESET_WAIT -> RUN (unconditionally after one cycle); RUN -> DRAIN on redirect with discard_cnt set > 0; DRAIN -> RUN when discard_cnt reaches 0; redirect in DRAIN reloads discard_cnt and stays in DRAIN.
REQ-021 SHALL, on simultaneous push and pop with FIFO full, complete both, with count unchanged.
REQ-022 SHALL give redirect priority over all same-cycle request, push and pop events.

Reset
REQ-023 SHALL on rst asynchronously set fetch_pc = 0, state = RESET_WAIT, outstanding = 0, discard_cnt = 0, FIFO/tag queue empty, imem_req_valid = 0, instr_valid = 0, instr/instr_pc = 0.
REQ-024 SHALL, on reset mid-operation, ignore responses to pre-reset requests only if environment also resets; no discard carried across reset.

Configuration
REQ-025 SHALL, with FETCH_PERF_EN defined, add output perf_redirects (16 bits, saturating at 0xFFFF, reset 0) counting accepted redirects and output perf_dropped (16 bits, saturating) counting discarded responses.
REQ-026 SHALL, without FETCH_PERF_EN, omit both ports and counters with no functional change.

Structure
REQ-027 SHALL place the FSM state enum (RESET_WAIT, RUN, DRAIN), PC_INCREMENT = 4 and FETCH_DEPTH = 2 in package fetch_pkg.
REQ-028 SHALL instantiate one sub-module fetch_fifo: a parameterised 2-entry FIFO holding {pc, instr}, with synchronous flush.

Verification
REQ-029 SHALL cover: reset, then imem_req_ready = 1 and 1-cycle responses -> instr_pc sequence 0x00, 0x04, 0x08, and imem_req_valid low in the first cycle.
REQ-030 SHALL cover: instr_ready = 0 -> at most 2 requests issued, then imem_req_valid stays 0 until a pop.
REQ-031 SHALL cover: redirect with base 0x10 and immext 0xFFFFFFF8 while 2 requests are outstanding -> next imem_addr = 0x08, both stale responses dropped, first delivered instr_pc = 0x08.
REQ-032 SHALL cover: fetch_pc at 0xFC -> next request at 0x00.
REQ-033 SHALL cover: redirect in DRAIN with a response arriving the same cycle -> response dropped, discard_cnt reloaded, FSM returns to RUN only after the last stale response.
REQ-034 SHALL cover: rst asserted mid-DRAIN -> all outputs 0 immediately, with FETCH_PERF_EN counters cleared.
